// File: rtl/dma_sequencer_if.sv
// Shared data-bus port of the DMA sequencer.
// The master drives address, write data and byte enables; the slave returns read data.
interface dma_sequencer_if;
    logic        dma_owns;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_wenable;
    logic [31:0] dma_rdata;

    modport master (
        output dma_owns, dma_addr, dma_wdata, dma_wenable,
        input  dma_rdata
    );

    modport slave (
        input  dma_owns, dma_addr, dma_wdata, dma_wenable,
        output dma_rdata
    );
endinterface

// File: rtl/dma_sequencer.sv
// Block-copy DMA engine on the shared CPU data bus, with optional vblank gating.
// Build option DMA_IRQ_EN adds the completion interrupt (irq output, CTRL bit4).
module dma_sequencer #(
    parameter int   LEN_WIDTH     = 16,
    parameter logic VBLANK_ACTIVE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   cfg_wenable,
    output logic [31:0]            cfg_rdata,
    input  logic                   vblank,
    dma_sequencer_if.master        bus,
    output logic                   irq
);
    // state | meaning
    // IDLE  | no transfer in progress, bus released
    // ARM   | word boundary: abort and vblank gate evaluated, bus released
    // RD    | source address driven on the bus
    // LATCH | read data captured into the word buffer
    // WR    | buffer written to destination, pointers and count advance
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RD, S_LATCH, S_WR} state_t;

    state_t               state, state_nx;
    logic [31:0]          src, dst, buffer;
    logic [LEN_WIDTH-1:0] len, remaining;
    logic                 wait_vblank_q, dst_fixed_q;
    logic                 done, aborted, abort_req;
    logic                 busy, ctrl_wr, start_req, start_abort_idle, abort_now, last_word;

    assign busy             = (state != S_IDLE);
    assign ctrl_wr          = cfg_wenable && (cfg_addr == 2'd3);
    assign start_req        = ctrl_wr && cfg_wdata[0] && !cfg_wdata[2] && !busy;
    assign start_abort_idle = ctrl_wr && cfg_wdata[0] && cfg_wdata[2] && !busy;
    assign abort_now        = abort_req || (ctrl_wr && cfg_wdata[2]);
    assign last_word        = (remaining == LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_req && (len != '0)) state_nx = S_ARM;
            S_ARM: begin
                if (abort_now)
                    state_nx = S_IDLE;
                else if (!wait_vblank_q || (vblank == VBLANK_ACTIVE))
                    state_nx = S_RD;
            end
            S_RD:    state_nx = S_LATCH;
            S_LATCH: state_nx = S_WR;
            S_WR:    state_nx = (last_word || abort_now) ? S_IDLE : S_ARM;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.dma_owns    = 1'b0;
        bus.dma_addr    = 32'd0;
        bus.dma_wdata   = 32'd0;
        bus.dma_wenable = 4'h0;
        case (state)
            S_RD, S_LATCH: begin
                bus.dma_owns = 1'b1;
                bus.dma_addr = {src[31:2], 2'b00};
            end
            S_WR: begin
                bus.dma_owns    = 1'b1;
                bus.dma_addr    = {dst[31:2], 2'b00};
                bus.dma_wdata   = buffer;
                bus.dma_wenable = 4'hF;
            end
            default: ;
        endcase
    end

`ifdef DMA_IRQ_EN
    logic irq_en_q, irq_q;
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            src           <= 32'd0;
            dst           <= 32'd0;
            buffer        <= 32'd0;
            len           <= '0;
            remaining     <= '0;
            wait_vblank_q <= 1'b0;
            dst_fixed_q   <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            abort_req     <= 1'b0;
`ifdef DMA_IRQ_EN
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
`endif
        end else begin
            if (cfg_wenable && !busy) begin
                case (cfg_addr)
                    2'd0:    src <= cfg_wdata;
                    2'd1:    dst <= cfg_wdata;
                    2'd2:    len <= cfg_wdata[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (start_req) begin
                done          <= (len == '0);
                aborted       <= 1'b0;
                abort_req     <= 1'b0;
                remaining     <= len;
                wait_vblank_q <= cfg_wdata[1];
                dst_fixed_q   <= cfg_wdata[3];
`ifdef DMA_IRQ_EN
                irq_en_q      <= cfg_wdata[4];
`endif
            end
            // Start and abort in one write: nothing moves, the whole block counts as untransferred.
            if (start_abort_idle) begin
                done      <= 1'b0;
                aborted   <= 1'b1;
                remaining <= len;
            end
            if (ctrl_wr && cfg_wdata[2] && busy) abort_req <= 1'b1;
            case (state)
                S_ARM: begin
                    if (abort_now) begin
                        aborted   <= 1'b1;
                        abort_req <= 1'b0;
                    end
                end
                S_LATCH: buffer <= bus.dma_rdata;
                S_WR: begin
                    src       <= src + 32'd4;
                    if (!dst_fixed_q) dst <= dst + 32'd4;
                    remaining <= remaining - LEN_WIDTH'(1);
                    abort_req <= 1'b0;
                    if (last_word)      done    <= 1'b1;
                    else if (abort_now) aborted <= 1'b1;
                end
                default: ;
            endcase
`ifdef DMA_IRQ_EN
            irq_q <= (start_req && (len == '0) && cfg_wdata[4]) ||
                     ((state == S_WR) && last_word && irq_en_q);
`endif
        end
    end

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0:    cfg_rdata = src;
            2'd1:    cfg_rdata = dst;
            2'd2:    cfg_rdata = 32'(len);
            default: cfg_rdata = {16'(remaining), 13'd0, aborted, done, busy};
        endcase
    end
endmodule
